// File: rtl/mem_access_pkg.sv
// rtl/mem_access_pkg.sv - size encodings, FSM states and alignment helper for mem_access_unit
package mem_access_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD,
        ST_WR,
        ST_RMW_RD,
        ST_RMW_WR,
        ST_RESP
    } state_t;

    // Size 2'b11 behaves as a word, so any size with bit 1 set needs offset 0.
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] off);
        return ((size == SZ_HALF) && off[0]) || (size[1] && (off != 2'b00));
    endfunction

endpackage

// File: rtl/mem_access_if.sv
// rtl/mem_access_if.sv - CPU request and memory bus bundle; misalign exists only with MISALIGN_TRAP_EN
interface mem_access_if;
    logic        req;
    logic        we;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        ready;
    logic        resp_valid;
    logic [31:0] rdata;
`ifdef MISALIGN_TRAP_EN
    logic        misalign;
`endif
    logic [31:0] adr;
    logic [31:0] writedata;
    logic        memread;
    logic        memwrite;
    logic [31:0] data;

    modport slave (
        input  req, we, size, uns, addr, wdata, data,
        output
`ifdef MISALIGN_TRAP_EN
               misalign,
`endif
               ready, resp_valid, rdata, adr, writedata, memread, memwrite
    );

    modport master (
        output req, we, size, uns, addr, wdata, data,
        input
`ifdef MISALIGN_TRAP_EN
               misalign,
`endif
               ready, resp_valid, rdata, adr, writedata, memread, memwrite
    );
endinterface

// File: rtl/be_lane_mux.sv
// rtl/be_lane_mux.sv - big-endian lane extract/extend for loads and lane merge for sub-word stores
module be_lane_mux
    import mem_access_pkg::*;
(
    input  logic [31:0] rd_word,
    input  logic [31:0] mrg_word,
    input  logic [1:0]  size,
    input  logic [1:0]  offset,
    input  logic        uns,
    input  logic [31:0] wdata,
    output logic [31:0] load_val,
    output logic [31:0] merged
);
    logic [7:0]  byte_v;
    logic [15:0] half_v;

    // Offset 0 is the most significant lane (big-endian).
    always_comb begin
        byte_v = rd_word[7:0];
        case (offset)
            2'd0:    byte_v = rd_word[31:24];
            2'd1:    byte_v = rd_word[23:16];
            2'd2:    byte_v = rd_word[15:8];
            default: byte_v = rd_word[7:0];
        endcase
        half_v = offset[1] ? rd_word[15:0] : rd_word[31:16];

        case (size)
            SZ_BYTE: load_val = {{24{~uns & byte_v[7]}}, byte_v};
            SZ_HALF: load_val = {{16{~uns & half_v[15]}}, half_v};
            default: load_val = rd_word;
        endcase
    end

    always_comb begin
        merged = mrg_word;
        case (size)
            SZ_BYTE: begin
                case (offset)
                    2'd0:    merged[31:24] = wdata[7:0];
                    2'd1:    merged[23:16] = wdata[7:0];
                    2'd2:    merged[15:8]  = wdata[7:0];
                    default: merged[7:0]   = wdata[7:0];
                endcase
            end
            SZ_HALF: begin
                if (offset[1]) merged[15:0]  = wdata[15:0];
                else           merged[31:16] = wdata[15:0];
            end
            default: merged = wdata;
        endcase
    end
endmodule

// File: rtl/mem_access_unit.sv
// rtl/mem_access_unit.sv - load/store FSM with read-modify-write for sub-word stores
// MISALIGN_TRAP_EN: misaligned half/word accesses respond at once with misalign=1 and no memory access.
module mem_access_unit
    import mem_access_pkg::*;
(
    input  logic         clk,
    input  logic         reset,
    mem_access_if.slave  bus
);
    state_t      state_q, state_d;
    logic [1:0]  size_q;
    logic        uns_q;
    logic [1:0]  off_q;
    logic [31:0] adr_q;
    logic [31:0] wdata_q;
    logic [31:0] rdata_q;
    logic [31:0] rmw_q;
    logic [31:0] load_val;
    logic [31:0] merged;
    logic        accept;
    logic        trap_now;
    logic        ready, resp_valid, memread, memwrite;
    logic [31:0] writedata;

    assign accept = (state_q == ST_IDLE) && bus.req;

`ifdef MISALIGN_TRAP_EN
    logic mis_q;
    assign trap_now     = is_misaligned(bus.size, bus.addr[1:0]);
    assign bus.misalign = (state_q == ST_RESP) && mis_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)       mis_q <= 1'b0;
        else if (accept) mis_q <= trap_now;
    end
`else
    assign trap_now = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            size_q  <= SZ_BYTE;
            uns_q   <= 1'b0;
            off_q   <= 2'b00;
            adr_q   <= 32'h0;
            wdata_q <= 32'h0;
            rdata_q <= 32'h0;
            rmw_q   <= 32'h0;
        end else begin
            if (accept) begin
                size_q  <= bus.size;
                uns_q   <= bus.uns;
                off_q   <= bus.addr[1:0];
                adr_q   <= {bus.addr[31:2], 2'b00};
                wdata_q <= bus.wdata;
            end
            if (state_q == ST_RD)     rdata_q <= load_val;
            if (state_q == ST_RMW_RD) rmw_q   <= bus.data;
        end
    end

    be_lane_mux u_lane (
        .rd_word  (bus.data),
        .mrg_word (rmw_q),
        .size     (size_q),
        .offset   (off_q),
        .uns      (uns_q),
        .wdata    (wdata_q),
        .load_val (load_val),
        .merged   (merged)
    );

    always_comb begin
        state_d    = state_q;
        ready      = 1'b0;
        resp_valid = 1'b0;
        memread    = 1'b0;
        memwrite   = 1'b0;
        writedata  = 32'h0;
        case (state_q)
            ST_IDLE: begin
                ready = 1'b1;
                if (bus.req) begin
                    if (trap_now)       state_d = ST_RESP;
                    else if (!bus.we)   state_d = ST_RD;
                    else if (bus.size[1]) state_d = ST_WR;
                    else                state_d = ST_RMW_RD;
                end
            end
            ST_RD: begin
                memread = 1'b1;
                state_d = ST_RESP;
            end
            ST_WR: begin
                memwrite  = 1'b1;
                writedata = wdata_q;
                state_d   = ST_RESP;
            end
            ST_RMW_RD: begin
                memread = 1'b1;
                state_d = ST_RMW_WR;
            end
            ST_RMW_WR: begin
                memwrite  = 1'b1;
                writedata = merged;
                state_d   = ST_RESP;
            end
            ST_RESP: begin
                resp_valid = 1'b1;
                state_d    = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign bus.ready      = ready;
    assign bus.resp_valid = resp_valid;
    assign bus.rdata      = rdata_q;
    assign bus.adr        = adr_q;
    assign bus.writedata  = writedata;
    assign bus.memread    = memread;
    assign bus.memwrite   = memwrite;
endmodule

// File: doc/mem_access_unit.md
MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 SHALL have one clock and reset: asynchronous and active-high.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 reset  input  1  asynchronous, active-high; forces IDLE.
REQ-004 req  input  1  CPU access request, sampled only while ready=1.
REQ-005 we  input  1  1=store, 0=load.
REQ-006 size  input  2  00 byte, 01 halfword, 10 word, 11 treated as word.
REQ-007 uns  input  1  1=zero-extend load, 0=sign-extend.
REQ-008 addr  input  32  CPU byte address.
REQ-009 wdata  input  32  store data, right-aligned.
REQ-010 ready  output  1  unit idle, may accept req.
REQ-011 resp_valid  output  1  one-cycle completion pulse.
REQ-012 rdata  output  32  extended load result, valid with resp_valid.
REQ-013 misalign  output  1  trap flag with resp_valid (MISALIGN_TRAP_EN only).
REQ-014 adr  output  32  word-aligned memory address (addr & ~3).
REQ-015 writedata  output  32  full word to memory.
REQ-016 memread / memwrite  output  1 each  memory strobes.
REQ-017 data  input  32  memory read word, combinational from adr/memread.

Function
REQ-018 Memory is big-endian: byte offset o=addr[1:0] occupies bits [31-8o:24-8o]; halfword offset h=addr[1] occupies [31-16h:16-16h].
REQ-019 FSM states IDLE, RD, WR, RMW_RD, RMW_WR, RESP; ready=1 only in IDLE.
REQ-020 IDLE & req: latch we/size/uns/addr/wdata; load->RD; word store->WR; byte/half store->RMW_RD.
REQ-021 RD: memread=1, capture extracted/extended lane at clock edge -> RESP.
REQ-022 WR: memwrite=1, writedata=wdata -> RESP.
REQ-023 RMW_RD: memread=1, capture data -> RMW_WR; RMW_WR: memwrite=1, writedata=captured word with target lane replaced by wdata low bits -> RESP.
REQ-024 RESP: resp_valid=1 for exactly one cycle -> IDLE; rdata holds last load value until next load completes.
REQ-025 Latency accept-to-resp_valid: load 2, word store 2, sub-word store 3 cycles.
REQ-026 req while ready=0 SHALL be ignored; CPU must hold req until accepted.
REQ-027 memread and memwrite SHALL never be 1 together; both 0 in IDLE and RESP.
REQ-028 Store rdata SHALL be unchanged; adr stable throughout an access.

Reset
REQ-029 reset SHALL immediately force IDLE, ready=1, resp_valid=0, misalign=0, rdata=0, memread=memwrite=0, adr=writedata=0, including mid-RMW (partial access abandoned, no write issued).

Configuration
REQ-030 Macro MISALIGN_TRAP_EN defined: halfword with addr[0]=1 or word with addr[1:0]!=0 SHALL go IDLE->RESP with misalign=1, no memory strobes, rdata unchanged.
REQ-031 Macro undefined: no misalign port; misaligned low bits SHALL be ignored (halfword uses addr[1], word uses offset 0).

Structure
REQ-032 Package mem_access_pkg SHALL hold size encodings and FSM state enum.
REQ-033 Combinational sub-module be_lane_mux SHALL perform lane extract/extend and lane merge; FSM stays in mem_access_unit.

Verification
REQ-034 Mem word @0x10=0x8012_34F0; load byte addr 0x13 uns=0 -> rdata 0xFFFF_FFF0 two cycles after accept.
REQ-035 Same word; load half addr 0x10 uns=1 -> rdata 0x0000_8012; uns=0 -> 0xFFFF_8012.
REQ-036 Store byte 0xAB to 0x11 over 0x8012_34F0 -> memwrite once, writedata 0x80AB_34F0, resp_valid 3 cycles after accept.
REQ-037 Word store 0xDEAD_BEEF to 0x20 then load word 0x20 -> rdata 0xDEAD_BEEF; req during busy ignored.
REQ-038 Assert reset during RMW_RD -> no memwrite, ready=1 same cycle; memory word unchanged.
REQ-039 MISALIGN_TRAP_EN: load word 0x22 -> resp_valid, misalign=1 one cycle after accept, no memread.
